output_buffer: RTL and testbench
================================

OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter DEPTH, 8, number of storage entries (power of two, >=2).
REQ-002 Parameter WIDTH, 9, data width in bits, signed two's complement, passed through unmodified.
REQ-003 Parameter VEC_LEN, 8, elements per output vector, used for o_last framing.
REQ-004 Port i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 Port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 Port i_clr  input  1  synchronous flush.
REQ-007 Port i_wr_en  input  1  write strobe from the normalization datapath.
REQ-008 Port i_wr_data  input  WIDTH  element to store.
REQ-009 Port i_ready  input  1  downstream consumer ready.
REQ-010 Port o_valid  output  1  o_data holds a valid element.
REQ-011 Port o_data  output  WIDTH  head-of-queue element.
REQ-012 Port o_last  output  1  the current o_data is the final element of a vector.
REQ-013 Port o_vec_done  output  1  one-cycle pulse after the last element of a vector is popped.
REQ-014 Port o_full  output  1  count == DEPTH.
REQ-015 Port o_empty  output  1  count == 0.
REQ-016 Port o_count  output  clog2(DEPTH)+1  number of stored entries.
REQ-017 Port o_overflow  output  1  sticky flag: a write was dropped.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries, with write and read pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 pop SHALL be o_valid && i_ready, and push SHALL be i_wr_en && (!o_full || pop).
REQ-020 o_valid SHALL equal !o_empty.
REQ-021 o_data SHALL be mem[rd_ptr] (show-ahead) and SHALL be all zeros when o_empty is high.
REQ-022 A push in cycle N SHALL make the element visible on o_data in cycle N+1 when the buffer was empty; latency is 1 cycle and there is no combinational path from i_wr_data to o_data.
REQ-023 While o_valid && !i_ready, o_data and o_last SHALL hold stable.
REQ-024 Count update: push&&!pop +1; pop&&!push -1; push&&pop unchanged.
REQ-025 A write when full with pop high in the same cycle SHALL be accepted, leaving count at DEPTH.
REQ-026 A write when full without pop SHALL be dropped, leave the pointers unchanged, and set o_overflow on the next edge.
REQ-027 o_overflow SHALL remain high until i_clr or reset.
REQ-028 An output index counter out_idx (0..VEC_LEN-1) SHALL increment on each pop and wrap to 0 after VEC_LEN-1.
REQ-029 o_last SHALL equal o_valid && (out_idx == VEC_LEN-1).
REQ-030 o_vec_done SHALL be registered high for exactly one cycle following a pop with o_last high.
REQ-031 i_clr SHALL zero the pointers, count, out_idx, o_overflow and o_vec_done on the next edge, and SHALL override a same-cycle push or pop (both are discarded).
REQ-032 Memory contents are not cleared by i_clr; the count governs validity.
REQ-033 i_ready while o_empty SHALL have no effect.

Reset
REQ-034 Assertion of i_rstn low SHALL asynchronously force the pointers, count and out_idx to 0, o_overflow to 0, o_vec_done to 0 and all memory entries to 0.
REQ-035 During and after reset, o_valid=0, o_data=0, o_last=0, o_empty=1, o_full=0, o_count=0.
REQ-036 Reset asserted mid-stream SHALL discard all stored data, and the first post-reset pop SHALL have out_idx=0.

Structure
REQ-037 Defaults for DEPTH, WIDTH and VEC_LEN SHALL reside in the shared layernorm package, alongside the input-side buffer constants.
REQ-038 No sub-module: storage, pointers and framing logic SHALL be inline in output_buffer.

Verification
REQ-039 Reset, then write 8 values -7..0 with i_ready=0 -> o_full=1, o_count=8; then hold i_ready=1 -> outputs -7..0 in order, o_last high only on 0, o_vec_done pulses one cycle later.
REQ-040 Full buffer, with i_wr_en=1 and i_ready=0 for 1 cycle -> o_overflow=1, o_count stays 8, and the dropped value never appears on o_data.
REQ-041 Full buffer, with i_wr_en=1 and i_ready=1 for 4 cycles writing 20..23 -> o_count stays 8 throughout, and the pointers wrap with correct FIFO order.
REQ-042 Empty buffer, single write of 5 at cycle N -> o_valid=1 and o_data=5 at N+1; with i_ready toggling 0,0,1, o_data holds 5 until popped.
REQ-043 After 3 pops mid-vector, assert i_clr together with i_wr_en -> o_count=0, o_overflow=0, and the next vector's o_last lands on its 8th element.
REQ-044 Assert i_rstn low asynchronously mid-stream -> all outputs take their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared layernorm constants: input-side and output-side buffer defaults.
package output_buffer_pkg;

    localparam int unsigned IB_DEPTH   = 8;
    localparam int unsigned IB_WIDTH   = 16;

    localparam int unsigned OB_DEPTH   = 8;
    localparam int unsigned OB_WIDTH   = 9;
    localparam int unsigned OB_VEC_LEN = 8;

endpackage

// File: rtl/output_buffer_if.sv
// Write/read/status bundle of the layernorm output buffer.
interface output_buffer_if
    import output_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = OB_DEPTH,
    parameter int unsigned WIDTH = OB_WIDTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             i_clr;
    logic             i_wr_en;
    logic [WIDTH-1:0] i_wr_data;
    logic             i_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic             o_vec_done;
    logic             o_full;
    logic             o_empty;
    logic [CNT_W-1:0] o_count;
    logic             o_overflow;

    // Producer/consumer side
    modport master (
        output i_clr, i_wr_en, i_wr_data, i_ready,
        input  o_valid, o_data, o_last, o_vec_done, o_full, o_empty, o_count, o_overflow
    );

    // Buffer side
    modport slave (
        input  i_clr, i_wr_en, i_wr_data, i_ready,
        output o_valid, o_data, o_last, o_vec_done, o_full, o_empty, o_count, o_overflow
    );
endinterface

// File: rtl/output_buffer.sv
// Show-ahead circular buffer with vector framing for the layernorm output stage.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = OB_DEPTH,
    parameter int unsigned WIDTH   = OB_WIDTH,
    parameter int unsigned VEC_LEN = OB_VEC_LEN
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    output_buffer_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             overflow_q, overflow_d;
    logic             vec_done_q, vec_done_d;

    logic full_c, empty_c, valid_c, last_c, pop_c, push_c, idx_wrap_c;

    // Status and handshake decode from registered state
    always_comb begin
        full_c     = (count_q == CNT_W'(DEPTH));
        empty_c    = (count_q == '0);
        valid_c    = !empty_c;
        idx_wrap_c = (out_idx_q == IDX_W'(VEC_LEN - 1));
        last_c     = valid_c && idx_wrap_c;
        pop_c      = valid_c && bus.i_ready;
        push_c     = bus.i_wr_en && (!full_c || pop_c);
    end

    // Next-state: clear overrides any same-cycle push/pop
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_idx_d  = out_idx_q;
        overflow_d = overflow_q;
        vec_done_d = 1'b0;
        if (bus.i_clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            out_idx_d  = '0;
            overflow_d = 1'b0;
        end else begin
            vec_done_d = pop_c && last_c;
            if (bus.i_wr_en && full_c && !pop_c) begin
                overflow_d = 1'b1;
            end
            if (push_c) begin
                mem_d[wr_ptr_q] = bus.i_wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                out_idx_d = idx_wrap_c ? '0 : out_idx_q + IDX_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, storage included in the asynchronous reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_idx_q  <= '0;
            overflow_q <= 1'b0;
            vec_done_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_idx_q  <= out_idx_d;
            overflow_q <= overflow_d;
            vec_done_q <= vec_done_d;
        end
    end

    assign bus.o_valid    = valid_c;
    assign bus.o_data     = empty_c ? '0 : mem_q[rd_ptr_q];
    assign bus.o_last     = last_c;
    assign bus.o_vec_done = vec_done_q;
    assign bus.o_full     = full_c;
    assign bus.o_empty    = empty_c;
    assign bus.o_count    = count_q;
    assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: stimulus queues expected pops, a monitor checks them.
module tb_output_buffer;
    import output_buffer_pkg::*;

    localparam int unsigned WIDTH = OB_WIDTH;

    typedef struct packed {
        logic signed [WIDTH-1:0] data;
        logic                    last;
    } exp_t;

    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    bit   vd_pend   = 1'b0;
    bit   rst_seen  = 1'b0;

    output_buffer_if #(.DEPTH(OB_DEPTH), .WIDTH(OB_WIDTH)) bus ();

    output_buffer #(.DEPTH(OB_DEPTH), .WIDTH(OB_WIDTH), .VEC_LEN(OB_VEC_LEN)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Write n consecutive values starting at first; last_at is the hand-computed
    // position (within this run) that pops with out_idx == VEC_LEN-1, or -1.
    task automatic write_seq(input int first, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_data = WIDTH'(first + i);
            sb.push_back('{data: WIDTH'(first + i), last: (i == last_at)});
            tick();
        end
        bus.i_wr_en = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.i_ready = 1'b1;
        repeat (n) tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    int'(bus.o_valid), 0);
        check({tag, "_data"},     int'(bus.o_data), 0);
        check({tag, "_last"},     int'(bus.o_last), 0);
        check({tag, "_empty"},    int'(bus.o_empty), 1);
        check({tag, "_full"},     int'(bus.o_full), 0);
        check({tag, "_count"},    int'(bus.o_count), 0);
        check({tag, "_overflow"}, int'(bus.o_overflow), 0);
        check({tag, "_vec_done"}, int'(bus.o_vec_done), 0);
    endtask

    always @(negedge i_rstn) rst_seen = 1'b1;

    // Monitor: every accepted pop must match the head of the scoreboard
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rstn || rst_seen) begin
            vd_pend  = 1'b0;
            rst_seen = 1'b0;
        end else begin
            check("vec_done", int'(bus.o_vec_done), int'(vd_pend));
            vd_pend = 1'b0;
            if (bus.o_valid && bus.i_ready && !bus.i_clr) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pop: got data %0d, expected no output", $signed(bus.o_data));
                end else begin
                    e = sb.pop_front();
                    check("pop_data", int'($signed(bus.o_data)), int'(e.data));
                    check("pop_last", int'(bus.o_last), int'(e.last));
                    vd_pend = e.last;
                end
            end
        end
    end

    initial begin
        bus.i_clr     = 1'b0;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = '0;
        bus.i_ready   = 1'b0;
        #12;
        check_reset_outputs("rst");
        i_rstn = 1'b1;
        tick();

        // Fill with -7..0 while stalled, then drain in order
        write_seq(-7, 8, 7);
        check("fill_full",  int'(bus.o_full), 1);
        check("fill_count", int'(bus.o_count), 8);
        drain(8);
        check("drain_empty", int'(bus.o_empty), 1);

        // Overflow: write into a full buffer without a pop is dropped
        write_seq(10, 8, 7);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = WIDTH'(99);
        tick();
        bus.i_wr_en = 1'b0;
        check("ovf_flag",  int'(bus.o_overflow), 1);
        check("ovf_count", int'(bus.o_count), 8);
        check("ovf_head",  int'($signed(bus.o_data)), 10);

        // Full buffer, simultaneous write and pop for 4 cycles
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_data = WIDTH'(20 + i);
            sb.push_back('{data: WIDTH'(20 + i), last: 1'b0});
            tick();
            check("wrap_count", int'(bus.o_count), 8);
        end
        bus.i_wr_en = 1'b0;
        drain(8);
        check("wrap_empty",    int'(bus.o_empty), 1);
        check("ovf_sticky",    int'(bus.o_overflow), 1);

        // Single write into empty buffer: visible next cycle, held while stalled
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = WIDTH'(5);
        sb.push_back('{data: WIDTH'(5), last: 1'b0});
        check("lat_pre_valid", int'(bus.o_valid), 0);
        tick();
        bus.i_wr_en = 1'b0;
        check("lat_valid", int'(bus.o_valid), 1);
        check("lat_data",  int'($signed(bus.o_data)), 5);
        tick();
        check("hold_data", int'($signed(bus.o_data)), 5);
        check("hold_last", int'(bus.o_last), 0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        check("single_empty", int'(bus.o_empty), 1);

        // Clear mid-vector together with a write and a pop
        write_seq(30, 8, 2);
        drain(3);
        bus.i_clr     = 1'b1;
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = WIDTH'(77);
        bus.i_ready   = 1'b1;
        sb.delete();
        tick();
        bus.i_clr   = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_ready = 1'b0;
        check("clr_count",    int'(bus.o_count), 0);
        check("clr_overflow", int'(bus.o_overflow), 0);
        check("clr_empty",    int'(bus.o_empty), 1);
        write_seq(40, 8, 7);
        drain(8);

        // Asynchronous reset mid-stream
        write_seq(50, 3, -1);
        #1;
        i_rstn = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("arst");
        tick();
        tick();
        #2;
        i_rstn = 1'b1;
        tick();
        check_reset_outputs("post_rst");
        write_seq(60, 8, 7);
        drain(8);

        tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
